idli_regs_wr_ctl_m: RTL and testbench
=====================================

# idli_regs_wr_ctl_m

Write-port controller and arbiter for the nibble-serial general-purpose register file (8x16b, rotating one 4b slice per cycle). It owns the 4-cycle slice phase, accepts full 16b writeback requests from the ALU and memory units, arbitrates between them, and serialises the winner into four phase-aligned nibble writes. It also publishes a per-register busy mask so issue logic can stall on in-flight writes.

## Interface
Parameters: none; widths come from the shared package.

Ports:
- i_wctl_gck  in  1  clock, the same clock that rotates the register file
- i_wctl_rst  in  1  reset, asynchronous, active-high
- i_wctl_alu_vld  in  1  ALU writeback request valid
- o_wctl_alu_rdy  out  1  ALU request accepted this cycle when vld&rdy
- i_wctl_alu_reg  in  greg_t (3)  ALU destination register
- i_wctl_alu_data  in  16  ALU write value
- i_wctl_mem_vld / o_wctl_mem_rdy / i_wctl_mem_reg / i_wctl_mem_data  same as the ALU set, for memory loads
- o_wctl_phase  out  2  current slice phase; nibble p of every register is presented during phase p
- o_wctl_wr_en  out  1  write the nibble this cycle
- o_wctl_wr_reg  out  greg_t (3)  register being written
- o_wctl_wr_data  out  sqi_data_t (4)  nibble for the current phase
- o_wctl_busy  out  8  one-hot mask of registers with a pending or in-flight write

## Operation
- Phase counter: increments modulo 4 every cycle; 3 wraps to 0.
- FSM states:
  - IDLE: no request held.
  - PEND: request latched, waiting for alignment.
  - WRITE: emitting nibbles during phases 0..3.
- Ready: both rdy outputs are combinational. rdy is high only to the arbitration winner, and only when state is IDLE, or when state is WRITE and phase==3. Both rdy outputs are low while reset is asserted.
- Arbitration:
  - Only one requester valid: it wins.
  - Both valid: round-robin. The winner is the requester not granted last.
  - The last-grant flag resets to MEM, so ALU wins the first tie.
- Accept: latch reg and data, then choose the next state from the current phase.
  - Accept at phase 3: next state WRITE, starting at phase 0.
  - Accept at any other phase: next state PEND.
- PEND: moves to WRITE when phase==3.
- WRITE:
  - Outputs: wr_en=1, wr_reg=latched reg, wr_data=data[4*phase+3 : 4*phase].
  - At phase 3 with a new accept: stay in WRITE (back-to-back, no bubble).
  - At phase 3 with no accept: go to IDLE.
- Outputs outside WRITE: wr_en=0; wr_reg and wr_data are don't-care and driven 0.
- busy: the bit of the latched register is set while in PEND or WRITE. It clears the cycle after the final nibble unless the same register is re-accepted.
- Reset mid-write: the register is left holding a mix of old and new nibbles. Software and the issue logic treat reset as a total state loss.

## Timing
- Reset values: phase=0, state=IDLE, wr_en=0, wr_reg=0, wr_data=0, busy=0, last-grant=MEM.
- Accept-to-first-nibble latency: 1 to 4 cycles, i.e. (4 − phase_at_accept) mod 4, with 4 when accepted at phase 0.
- Accept-to-complete: first-nibble latency + 3 cycles.
- Sustained throughput: one 16b write every 4 cycles.
- Requesters must hold vld, reg and data stable until rdy. Dropping vld before rdy is permitted, and the request is then simply not taken.

## Configuration
- IDLI_WCTL_R0_ZERO_EN defined: register 0 is hard-wired zero.
  - Requests to reg 0 still handshake and occupy the slot.
  - wr_en stays 0 throughout that WRITE.
  - busy bit 0 never sets.
- Macro undefined: reg 0 is written like any other register.

## Structure
- Shared package idli_pkg holds:
  - existing greg_t (3b) and sqi_data_t (4b)
  - new wctl_phase_t (2b)
  - new wctl_state_t enum {IDLE, PEND, WRITE}
  - new wctl_req_t struct {greg_t reg; logic [15:0] data}
- One sub-module, idli_wctl_arb_m: 2-way round-robin arbiter (vld in, grant out, update on accept).

## Test plan
- Reset release, ALU request reg 3 = 0xBEEF at phase 1 → rdy same cycle, PEND 2 cycles, then wr_en for 4 cycles with data F,E,E,B at phases 0..3 and wr_reg=3; busy=0x08 from accept until after phase 3.
- ALU and MEM both valid at phase 3 from reset → ALU granted, WRITE starts the next cycle; MEM granted at the following phase 3 with no bubble and wr_en continuous for 8 cycles.
- Both valid on three consecutive slots → grants alternate ALU, MEM, ALU.
- MEM request to reg 0 = 0x1234 → with IDLI_WCTL_R0_ZERO_EN: handshake occurs, wr_en stays 0, busy stays 0. Without the macro: nibbles 4,3,2,1 are written to reg 0.
- Assert reset during WRITE phase 2 → wr_en=0, phase=0, busy=0, state IDLE immediately; a new request after release completes normally.
- Request valid at phase 0 then withdrawn before rdy (held while busy) → no accept, no wr_en, last-grant unchanged.

Source files
------------

// File: rtl/idli_pkg.sv
// idli_pkg: shared register-file types plus the write-controller types
package idli_pkg;
   typedef logic [2:0] greg_t;
   typedef logic [3:0] sqi_data_t;
   typedef logic [1:0] wctl_phase_t;
   typedef enum logic [1:0] {WCTL_IDLE, WCTL_PEND, WCTL_WRITE} wctl_state_t;
   typedef struct packed {
      greg_t      wreg;
      logic [15:0] data;
   } wctl_req_t;
endpackage

// File: rtl/idli_regs_wr_ctl_m_if.sv
// idli_regs_wr_ctl_m_if: writeback requests (alu_*, mem_*) and nibble write port (phase, wr_*, busy)
interface idli_regs_wr_ctl_m_if;
   import idli_pkg::*;
   logic        alu_vld;
   logic        alu_rdy;
   greg_t       alu_reg;
   logic [15:0] alu_data;
   logic        mem_vld;
   logic        mem_rdy;
   greg_t       mem_reg;
   logic [15:0] mem_data;
   wctl_phase_t phase;
   logic        wr_en;
   greg_t       wr_reg;
   sqi_data_t   wr_data;
   logic [7:0]  busy;
   modport master (
      output alu_vld, alu_reg, alu_data, mem_vld, mem_reg, mem_data,
      input  alu_rdy, mem_rdy, phase, wr_en, wr_reg, wr_data, busy
   );
   modport slave (
      input  alu_vld, alu_reg, alu_data, mem_vld, mem_reg, mem_data,
      output alu_rdy, mem_rdy, phase, wr_en, wr_reg, wr_data, busy
   );
endinterface

// File: rtl/idli_wctl_arb_m.sv
// idli_wctl_arb_m: 2-way round-robin arbiter; ports clk, rst, alu_vld/mem_vld in, alu_gnt/mem_gnt out, upd = grant taken
module idli_wctl_arb_m (
   input  logic clk,
   input  logic rst,
   input  logic alu_vld,
   input  logic mem_vld,
   input  logic upd,
   output logic alu_gnt,
   output logic mem_gnt
);
   logic last_mem;
   always_comb begin
      alu_gnt = alu_vld & (~mem_vld | last_mem);
      mem_gnt = mem_vld & (~alu_vld | ~last_mem);
   end
   // resets to MEM so the ALU wins the first tie
   always_ff @(posedge clk or posedge rst)
      if (rst) last_mem <= 1'b1;
      else if (upd) last_mem <= mem_gnt;
endmodule

// File: rtl/idli_regs_wr_ctl_m.sv
// idli_regs_wr_ctl_m: write-port controller; ports i_wctl_gck, i_wctl_rst, wctl (slave: requests in, nibble writes/busy out); macro IDLI_WCTL_R0_ZERO_EN hard-wires reg 0 to zero
module idli_regs_wr_ctl_m
   import idli_pkg::*;
(
   input logic                 i_wctl_gck,
   input logic                 i_wctl_rst,
   idli_regs_wr_ctl_m_if.slave wctl
);
   localparam logic [1:0] IDLE  = WCTL_IDLE;
   localparam logic [1:0] PEND  = WCTL_PEND;
   localparam logic [1:0] WRITE = WCTL_WRITE;
   wctl_phase_t phase;
   logic [1:0]  state, state_nx;
   wctl_req_t   req;
   logic        alu_gnt, mem_gnt, slot, acc, r0;
   idli_wctl_arb_m u_arb (
      .clk     (i_wctl_gck),
      .rst     (i_wctl_rst),
      .alu_vld (wctl.alu_vld),
      .mem_vld (wctl.mem_vld),
      .upd     (acc),
      .alu_gnt (alu_gnt),
      .mem_gnt (mem_gnt)
   );
   always_comb begin
      // a new request fits when idle or while the last nibble goes out
      slot         = ~i_wctl_rst & ((state == IDLE) | ((state == WRITE) & (phase == 2'd3)));
      wctl.alu_rdy = slot & alu_gnt;
      wctl.mem_rdy = slot & mem_gnt;
      acc          = wctl.alu_rdy | wctl.mem_rdy;
      state_nx     = (state == PEND) ? ((phase == 2'd3) ? WRITE : PEND)
                   : ((state == WRITE) & (phase != 2'd3)) ? WRITE
                   : acc ? ((phase == 2'd3) ? WRITE : PEND) : IDLE;
`ifdef IDLI_WCTL_R0_ZERO_EN
      r0           = (req.wreg == 3'd0);
`else
      r0           = 1'b0;
`endif
      wctl.phase   = phase;
      wctl.wr_en   = (state == WRITE) & ~r0;
      wctl.wr_reg  = (state == WRITE) ? req.wreg : 3'd0;
      wctl.wr_data = (state == WRITE) ? req.data[{phase, 2'b00} +: 4] : 4'd0;
      wctl.busy    = (((state == PEND) | (state == WRITE)) & ~r0) ? (8'd1 << req.wreg) : 8'd0;
   end
   always_ff @(posedge i_wctl_gck or posedge i_wctl_rst)
      if (i_wctl_rst) begin
         phase <= 2'd0;
         state <= IDLE;
         req   <= '0;
      end else begin
         phase <= phase + 2'd1;
         state <= state_nx;
         if (acc) req <= alu_gnt ? wctl_req_t'{wreg: wctl.alu_reg, data: wctl.alu_data}
                                 : wctl_req_t'{wreg: wctl.mem_reg, data: wctl.mem_data};
      end
endmodule

// File: tb/tb_idli_regs_wr_ctl_m.sv
// tb_idli_regs_wr_ctl_m: directed self-checking bench for the register write controller
module tb_idli_regs_wr_ctl_m;
   import idli_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   idli_regs_wr_ctl_m_if bus ();
   idli_regs_wr_ctl_m dut (.i_wctl_gck(clk), .i_wctl_rst(rst), .wctl(bus));
   always #5 clk = ~clk;
   function automatic logic [15:0] obs();
      return {bus.wr_en, bus.wr_reg, bus.wr_data, bus.busy};
   endfunction
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask
   task automatic idle_in();
      bus.alu_vld = 1'b0; bus.alu_reg = 3'd0; bus.alu_data = 16'h0;
      bus.mem_vld = 1'b0; bus.mem_reg = 3'd0; bus.mem_data = 16'h0;
   endtask
   task automatic do_reset();
      idle_in();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      #1;
   endtask
   task automatic test_reset();
      idle_in();
      rst = 1'b1;
      bus.alu_vld = 1'b1;
      bus.mem_vld = 1'b1;
      step(2);
      #1;
      n_cmp++;
      if ({bus.phase, obs()} !== 18'h0) begin
         n_bad++; $display("FAIL reset_outputs got %h exp 00000", {bus.phase, obs()});
      end
      n_cmp++;
      if ({bus.alu_rdy, bus.mem_rdy} !== 2'b00) begin
         n_bad++; $display("FAIL reset_rdy got %b exp 00", {bus.alu_rdy, bus.mem_rdy});
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({bus.alu_rdy, bus.mem_rdy} !== 2'b10) begin
         n_bad++; $display("FAIL first_tie got %b exp 10", {bus.alu_rdy, bus.mem_rdy});
      end
      idle_in();
   endtask
   task automatic test_single();
      logic [15:0] exp_t [7] = '{16'h0008, 16'h0008, 16'hBF08, 16'hBE08, 16'hBE08, 16'hBB08, 16'h0000};
      do_reset();
      step(1);
      bus.alu_vld = 1'b1; bus.alu_reg = 3'd3; bus.alu_data = 16'hBEEF;
      #1;
      n_cmp++;
      if ({bus.phase, bus.alu_rdy, bus.mem_rdy} !== 4'b0110) begin
         n_bad++; $display("FAIL single_accept got %b exp 0110", {bus.phase, bus.alu_rdy, bus.mem_rdy});
      end
      for (int k = 0; k < 7; k++) begin
         step(1);
         if (k == 0) idle_in();
         #1;
         n_cmp++;
         if (obs() !== exp_t[k]) begin
            n_bad++; $display("FAIL single k=%0d got %h exp %h", k, obs(), exp_t[k]);
         end
      end
   endtask
   task automatic test_back_to_back();
      logic [15:0] exp_t [9] = '{16'h9302, 16'h9C02, 16'h9502, 16'h9A02,
                                 16'hA804, 16'hA704, 16'hA604, 16'hA504, 16'h0000};
      do_reset();
      step(3);
      bus.alu_vld = 1'b1; bus.alu_reg = 3'd1; bus.alu_data = 16'hA5C3;
      bus.mem_vld = 1'b1; bus.mem_reg = 3'd2; bus.mem_data = 16'h5678;
      #1;
      n_cmp++;
      if ({bus.phase, bus.alu_rdy, bus.mem_rdy} !== 4'b1110) begin
         n_bad++; $display("FAIL b2b_first got %b exp 1110", {bus.phase, bus.alu_rdy, bus.mem_rdy});
      end
      for (int k = 0; k < 9; k++) begin
         step(1);
         if (k == 0) bus.alu_vld = 1'b0;
         if (k == 4) bus.mem_vld = 1'b0;
         #1;
         n_cmp++;
         if ({obs(), bus.alu_rdy, bus.mem_rdy} !== {exp_t[k], 1'b0, k == 3}) begin
            n_bad++; $display("FAIL b2b k=%0d got %h/%b exp %h/%b", k, obs(),
                              {bus.alu_rdy, bus.mem_rdy}, exp_t[k], {1'b0, k == 3});
         end
      end
   endtask
   task automatic test_round_robin();
      int cyc [3] = '{0, 7, 11};
      logic [1:0] gnt [3] = '{2'b10, 2'b01, 2'b10};
      int n = 0;
      int c = 0;
      do_reset();
      bus.alu_vld = 1'b1; bus.alu_reg = 3'd6; bus.alu_data = 16'h1111;
      bus.mem_vld = 1'b1; bus.mem_reg = 3'd7; bus.mem_data = 16'h2222;
      while (n < 3 && c < 16) begin
         #1;
         if (bus.alu_rdy | bus.mem_rdy) begin
            n_cmp++;
            if ({c, bus.alu_rdy, bus.mem_rdy} !== {cyc[n], gnt[n]}) begin
               n_bad++; $display("FAIL rr grant%0d got cyc %0d %b exp cyc %0d %b", n, c,
                                 {bus.alu_rdy, bus.mem_rdy}, cyc[n], gnt[n]);
            end
            n++;
         end
         step(1);
         c++;
      end
      n_cmp++;
      if (n !== 3) begin
         n_bad++; $display("FAIL rr_count got %0d exp 3", n);
      end
      idle_in();
   endtask
   task automatic test_r0();
`ifdef IDLI_WCTL_R0_ZERO_EN
      logic [15:0] exp_t [8] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      logic [15:0] mask = 16'h80FF;
`else
      logic [15:0] exp_t [8] = '{16'h0001, 16'h0001, 16'h0001, 16'h8401,
                                 16'h8301, 16'h8201, 16'h8101, 16'h0000};
      logic [15:0] mask = 16'hFFFF;
`endif
      do_reset();
      bus.mem_vld = 1'b1; bus.mem_reg = 3'd0; bus.mem_data = 16'h1234;
      #1;
      n_cmp++;
      if ({bus.alu_rdy, bus.mem_rdy} !== 2'b01) begin
         n_bad++; $display("FAIL r0_accept got %b exp 01", {bus.alu_rdy, bus.mem_rdy});
      end
      for (int k = 0; k < 8; k++) begin
         step(1);
         if (k == 0) idle_in();
         #1;
         n_cmp++;
         if ((obs() & mask) !== exp_t[k]) begin
            n_bad++; $display("FAIL r0 k=%0d got %h exp %h", k, obs() & mask, exp_t[k]);
         end
      end
   endtask
   task automatic test_reset_mid();
      logic [15:0] exp_t [8] = '{16'h0040, 16'h0040, 16'h0040, 16'hEF40,
                                 16'hE040, 16'hEF40, 16'hE040, 16'h0000};
      do_reset();
      bus.alu_vld = 1'b1; bus.alu_reg = 3'd5; bus.alu_data = 16'h9ABC;
      step(1);
      idle_in();
      step(5);
      #1;
      n_cmp++;
      if ({bus.phase, obs()} !== {2'd2, 16'hDA20}) begin
         n_bad++; $display("FAIL mid_write got %h exp 2da20", {bus.phase, obs()});
      end
      bus.alu_vld = 1'b1; bus.alu_reg = 3'd6; bus.alu_data = 16'h0F0F;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({bus.phase, obs(), bus.alu_rdy, bus.mem_rdy} !== 20'h0) begin
         n_bad++; $display("FAIL mid_reset got %h exp 00000", {bus.phase, obs(), bus.alu_rdy, bus.mem_rdy});
      end
      step(1);
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({bus.phase, bus.alu_rdy} !== 3'b001) begin
         n_bad++; $display("FAIL post_reset_rdy got %b exp 001", {bus.phase, bus.alu_rdy});
      end
      for (int k = 0; k < 8; k++) begin
         step(1);
         if (k == 0) idle_in();
         #1;
         n_cmp++;
         if (obs() !== exp_t[k]) begin
            n_bad++; $display("FAIL post_reset k=%0d got %h exp %h", k, obs(), exp_t[k]);
         end
      end
   endtask
   task automatic test_withdraw();
      do_reset();
      bus.alu_vld = 1'b1; bus.alu_reg = 3'd1; bus.alu_data = 16'h4321;
      step(1);
      idle_in();
      step(3);
      bus.mem_vld = 1'b1; bus.mem_reg = 3'd4; bus.mem_data = 16'hFFFF;
      #1;
      for (int k = 3; k < 8; k++) begin
         if (k == 5) begin
            idle_in();
            #1;
         end
         n_cmp++;
         if ({obs(), bus.mem_rdy} !== ((k < 7) ? {16'h9002 | (16'(k - 3) == 16'd0 ? 16'h0100 : 16'h0) | (k == 4 ? 16'h0200 : 16'h0) | (k == 5 ? 16'h0300 : 16'h0) | (k == 6 ? 16'h0400 : 16'h0), 1'b0} : 17'h0)) begin
            n_bad++; $display("FAIL withdraw k=%0d got %h/%b", k, obs(), bus.mem_rdy);
         end
         step(1);
         #1;
      end
      bus.alu_vld = 1'b1; bus.mem_vld = 1'b1;
      #1;
      n_cmp++;
      if ({bus.alu_rdy, bus.mem_rdy} !== 2'b01) begin
         n_bad++; $display("FAIL withdraw_lastgrant got %b exp 01", {bus.alu_rdy, bus.mem_rdy});
      end
      idle_in();
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_round_robin();
      test_r0();
      test_reset_mid();
      test_withdraw();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
